// File: rtl/divider_param.sv
// Iterative restoring divider: one quotient bit per cycle, valid/ready operand and result streams.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds a SIGNFIX state).
module divider_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] dividend_data,
    input  logic             dividend_valid,
    output logic             dividend_ready,
    input  logic [WIDTH-1:0] divisor_data,
    input  logic             divisor_valid,
    output logic             divisor_ready,
    output logic [WIDTH-1:0] quotient_data,
    output logic [WIDTH-1:0] remainder_data,
    output logic             div_by_zero,
    output logic             quotient_valid,
    input  logic             quotient_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

`ifdef DIVIDER_SIGNED_EN
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ZERO, S_SIGNFIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ZERO, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic             r_ready;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;
`ifdef DIVIDER_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_next;

    assign w_accept = r_ready & dividend_valid & divisor_valid;

`ifdef DIVIDER_SIGNED_EN
    assign w_dvd_mag = dividend_data[WIDTH-1] ? (-dividend_data) : dividend_data;
    assign w_dvs_mag = divisor_data[WIDTH-1]  ? (-divisor_data)  : divisor_data;
`else
    assign w_dvd_mag = dividend_data;
    assign w_dvs_mag = divisor_data;
`endif

    // Partial remainder kept one bit wider so the shifted value never overflows;
    // the sign of the difference doubles as the compare result.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_q_next    = {r_q[WIDTH-2:0], w_ge};
    assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_quot    <= '0;
            r_remd    <= '0;
            r_dbz     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH - 1);
                        r_divisor <= w_dvs_mag;
`ifdef DIVIDER_SIGNED_EN
                        r_neg_q   <= dividend_data[WIDTH-1] ^ divisor_data[WIDTH-1];
                        r_neg_r   <= dividend_data[WIDTH-1];
`endif
                        // ZERO reports the raw dividend, so keep it unmodified there.
                        if (divisor_data == '0) begin
                            r_q     <= dividend_data;
                            r_state <= S_ZERO;
                        end else begin
                            r_q     <= w_dvd_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    if (r_cnt == '0) begin
`ifdef DIVIDER_SIGNED_EN
                        r_state <= S_SIGNFIX;
`else
                        r_quot  <= w_q_next;
                        r_remd  <= w_rem_next;
                        r_dbz   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`ifdef DIVIDER_SIGNED_EN
                S_SIGNFIX: begin
                    r_quot  <= r_neg_q ? (-r_q) : r_q;
                    r_remd  <= r_neg_r ? (-r_rem) : r_rem;
                    r_dbz   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_ZERO: begin
                    r_quot  <= '1;
                    r_remd  <= r_q;
                    r_dbz   <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (quotient_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dividend_ready = r_ready;
    assign divisor_ready  = r_ready;
    assign quotient_data  = r_quot;
    assign remainder_data = r_remd;
    assign div_by_zero    = r_dbz;
    assign quotient_valid = r_valid;
    assign busy           = r_busy;

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench for divider_param: driver pushes model results on accept, monitor pops on handshake.
// With DIVIDER_SIGNED_EN defined the bench runs the signed build at WIDTH=8.
module tb_divider_param;

`ifdef DIVIDER_SIGNED_EN
    localparam int W   = 8;
    localparam int LAT = W + 2;
`else
    localparam int W   = 16;
    localparam int LAT = W + 1;
`endif
    localparam int ZLAT = 2;

    logic         clk = 1'b0;
    logic         arst;
    logic [W-1:0] dividend_data;
    logic         dividend_valid;
    logic         dividend_ready;
    logic [W-1:0] divisor_data;
    logic         divisor_valid;
    logic         divisor_ready;
    logic [W-1:0] quotient_data;
    logic [W-1:0] remainder_data;
    logic         div_by_zero;
    logic         quotient_valid;
    logic         quotient_ready;
    logic         busy;

    always #5 clk = ~clk;

    divider_param #(.WIDTH(W)) dut (
        .clk(clk), .arst(arst),
        .dividend_data(dividend_data), .dividend_valid(dividend_valid), .dividend_ready(dividend_ready),
        .divisor_data(divisor_data), .divisor_valid(divisor_valid), .divisor_ready(divisor_ready),
        .quotient_data(quotient_data), .remainder_data(remainder_data), .div_by_zero(div_by_zero),
        .quotient_valid(quotient_valid), .quotient_ready(quotient_ready), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    int   acc_cyc[$];
    int   acc_lat[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_results = 0;
    int   cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, qq, rr;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'(a);
            sb = longint'(b);
`endif
            qq  = sa / sb;
            rr  = sa % sb;
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor
    logic         prev_valid = 1'b0;
    logic         stall_chk  = 1'b0;
    logic         rdy_chk    = 1'b0;
    logic [W-1:0] sv_q, sv_r;
    logic         sv_z;

    always @(negedge clk) begin
        if (arst) begin
            prev_valid = 1'b0;
            stall_chk  = 1'b0;
            rdy_chk    = 1'b0;
        end else begin
            if (rdy_chk) begin
                check("ready_after_handshake", {61'd0, dividend_ready, divisor_ready, quotient_valid}, 64'b110);
                rdy_chk = 1'b0;
            end
            if (dividend_valid && divisor_valid && dividend_ready && divisor_ready) begin
                sb_q.push_back(model(dividend_data, divisor_data));
                acc_cyc.push_back(cyc);
                acc_lat.push_back((divisor_data == '0) ? ZLAT : LAT);
            end
            if (quotient_valid && !prev_valid) begin
                if (acc_cyc.size() == 0) check("stale_valid", quotient_valid, 0);
                else check("latency", cyc - acc_cyc.pop_front(), acc_lat.pop_front());
            end
            if (stall_chk) begin
                check("stall_quotient", quotient_data, sv_q);
                check("stall_remainder", remainder_data, sv_r);
                check("stall_dbz", div_by_zero, sv_z);
                check("stall_valid", quotient_valid, 1);
            end
            stall_chk = 1'b0;
            if (quotient_valid) begin
                if (!quotient_ready) begin
                    sv_q = quotient_data;
                    sv_r = remainder_data;
                    sv_z = div_by_zero;
                    stall_chk = 1'b1;
                end else if (sb_q.size() == 0) begin
                    check("orphan_result", quotient_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("quotient", quotient_data, e.q);
                    check("remainder", remainder_data, e.r);
                    check("div_by_zero", div_by_zero, e.z);
                    n_results++;
                    rdy_chk = 1'b1;
                end
            end
            prev_valid = quotient_valid;
        end
    end

    // Driver
    task automatic check_reset_values();
        check("rst_flags", {59'd0, dividend_ready, divisor_ready, quotient_valid, div_by_zero, busy}, 64'b11000);
        check("rst_quotient", quotient_data, 0);
        check("rst_remainder", remainder_data, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
        bit accepted = 1'b0;
        dividend_data  = a;
        divisor_data   = b;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            accepted = dividend_ready && divisor_ready;
            @(posedge clk);
            #2;
            if (rnd) quotient_ready = ($urandom_range(0, 3) != 0);
        end
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        if (!accepted) check("accept_timeout", {63'd0, accepted}, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        quotient_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (sb_q.size() == 0) && !quotient_valid;
        end
        @(posedge clk);
        #2;
        if (!done) check("drain_timeout", {63'd0, done}, 1);
    endtask

    initial begin
        int n0;
        bit seen;
        logic [W-1:0] ra, rb;
        arst = 1'b1;
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        dividend_data  = '0;
        divisor_data   = '0;
        quotient_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        arst = 1'b0;
        @(posedge clk);
        #2;

`ifdef DIVIDER_SIGNED_EN
        do_op(8'hF9, 8'd2, 0);  drain();
        do_op(8'd7, 8'hFE, 0);  drain();
        do_op(8'h80, 8'hFF, 0); drain();
        do_op(8'h92, 8'd0, 0);  drain();
        do_op(8'h80, 8'd1, 0);
        do_op(8'h85, 8'd9, 0);
        do_op(8'd5, 8'hF7, 0);  drain();
`else
        do_op(16'd100, 16'd7, 0);    drain();
        do_op(16'h1234, 16'd0, 0);   drain();
        do_op(16'hFFFF, 16'd1, 0);
        do_op(16'd5, 16'd9, 0);
        do_op(16'hFFFF, 16'hFFFF, 0); drain();
`endif

        // Skewed operands, then back-pressure in DONE
        quotient_ready = 1'b0;
        n0 = n_results;
        dividend_data  = W'(40000);
        divisor_data   = W'(123);
        dividend_valid = 1'b1;
        divisor_valid  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("lone_valid_not_taken", {62'd0, dividend_ready, busy}, 64'b10);
            @(posedge clk);
            #2;
        end
        do_op(W'(40000), W'(123), 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = quotient_valid;
        end
        check("stall_valid_timeout", {63'd0, seen}, 1);
        repeat (5) @(posedge clk);
        #2;
        drain();
        check("one_result", n_results - n0, 1);

        // Reset during CALC
        do_op(W'(1000), W'(3), 0);
        repeat (6) @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check_reset_values();
        sb_q.delete();
        acc_cyc.delete();
        acc_lat.delete();
        @(posedge clk);
        #2;
        arst = 1'b0;
        do_op(W'(50), W'(5), 0);
        drain();

        // Random stream with random back-pressure
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1, 2, 3: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            do_op(ra, rb, 1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider_param.md
Name: divider_param

Overview:
- Parametrised iterative unsigned integer divider (restoring, one quotient bit per cycle).
- Successor to the fixed 16-bit divider: adds a width parameter, remainder output, divide-by-zero detection, back-pressure-safe result holding, and an optional signed mode.
- Sits between valid/ready producer streams (dividend, divisor) and a valid/ready consumer, in the same clock domain.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 2..64).

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- dividend_data  in  WIDTH  dividend operand.
- dividend_valid  in  1  dividend offered.
- dividend_ready  out  1  divider can accept dividend.
- divisor_data  in  WIDTH  divisor operand.
- divisor_valid  in  1  divisor offered.
- divisor_ready  out  1  divider can accept divisor.
- quotient_data  out  WIDTH  quotient result.
- remainder_data  out  WIDTH  remainder result.
- div_by_zero  out  1  result qualifier: divisor was zero.
- quotient_valid  out  1  result bundle valid.
- quotient_ready  in  1  consumer accepts result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (arst).
- Reset (async assert, sync release): state=IDLE.
  - dividend_ready=1, divisor_ready=1 (registered; IDLE value).
  - quotient_valid=0, quotient_data=0, remainder_data=0, div_by_zero=0, busy=0.
  - Internal counter, partial remainder and operand registers cleared.
- dividend_ready = divisor_ready = (state==IDLE). Both are registered.
- Accept: only in IDLE with dividend_valid && divisor_valid on the same edge. Both operands are latched together.
  - A lone valid is not consumed. The matching ready stays high and no transfer occurs.
- States:
  - IDLE: on accept, go to ZERO if divisor==0, else to CALC with count=WIDTH-1, rem=0, q=dividend.
  - CALC: each cycle, rem' = {rem[WIDTH-2:0], q[WIDTH-1]}; shift q left.
    - If rem' >= divisor: rem = rem' - divisor and q[0]=1; else q[0]=0.
    - The compare and subtract use WIDTH+1 bits to avoid overflow.
    - When count==0, load the result registers and go to DONE; else decrement count.
  - ZERO: load quotient_data = all ones, remainder_data = dividend, div_by_zero=1; go to DONE.
  - DONE: quotient_valid=1. Hold all result outputs stable until quotient_ready=1.
    - On handshake: quotient_valid=0 next cycle, state goes to IDLE, ready=1 next cycle.
- Latency, measured from the accept edge to the first cycle with quotient_valid=1:
  - Nonzero divisor: WIDTH+1 cycles.
  - Zero divisor: 2 cycles.
- Throughput: one operation per WIDTH+2 cycles when quotient_ready is held high.
- div_by_zero is 0 for every non-zero-divisor result. It is valid only with quotient_valid.
- quotient_ready while quotient_valid=0 is ignored.
- Result registers change only on the transition into DONE; they are stable throughout DONE.
- Operands presented while busy are not accepted and must be held by the producer (standard valid/ready).
- arst asserted mid-CALC or mid-DONE: immediate return to reset state. The in-flight result is discarded and never presented.
- Dividend < divisor: quotient=0, remainder=dividend.
- Dividend = all ones, divisor = 1: quotient = all ones, remainder=0.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: operands and results are two's complement.
  - Magnitudes are taken on accept and divided unsigned. A SIGNFIX state is inserted between CALC and DONE: latency WIDTH+2 cycles, throughput one per WIDTH+3 cycles.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / -1: quotient=MIN (wraps), remainder=0, div_by_zero=0.
  - Divide by zero: quotient=-1 (all ones), remainder=dividend, div_by_zero=1, latency 2 cycles.
- Undefined: pure unsigned as above, and no SIGNFIX state exists.

Test Plan (WIDTH=16 unless stated):
- Basic: 100 / 7 presented together with quotient_ready=1 -> quotient 14, remainder 2, div_by_zero=0; quotient_valid rises exactly 17 cycles after accept; ready returns high the cycle after the result handshake.
- Zero divisor: 0x1234 / 0 -> quotient 0xFFFF, remainder 0x1234, div_by_zero=1, valid 2 cycles after accept.
- Back-pressure and skew: dividend_valid asserted 3 cycles before divisor_valid, and quotient_ready held 0 for 5 cycles in DONE -> no accept until both are valid; outputs stable while stalled; exactly one result delivered.
- Extremes: 0xFFFF/1 -> 0xFFFF rem 0; 5/9 -> 0 rem 5; 0xFFFF/0xFFFF -> 1 rem 0. Back-to-back stream of 200 random pairs, checked against a reference model.
- Reset mid-operation: assert arst 6 cycles after accepting 1000/3 -> all outputs at reset values immediately; next operation 50/5 -> 10 rem 0, with no stale valid.
- Signed (DIVIDER_SIGNED_EN, WIDTH=8): -7/2 -> -3 rem -1; 7/-2 -> -3 rem 1; -128/-1 -> -128 rem 0; latency 10 cycles.
